// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID pipeline register between instruction fetch and decode.
//
// Captures the fetched PC and instruction every cycle. A freeze (load-use
// stall) holds the current contents. A flush (taken branch) inserts a bubble.
// A valid bit marks real instructions. Two saturating event counters, for
// performance debug, count stall cycles and flush cycles.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   pcIn        PC from fetch stage (address of instrIn)
//   instrIn     instruction word from fetch stage
//   freeze      hold current contents
//   flush       squash wrong-path fetch (has priority over freeze)
//   PC          registered PC to decode
//   instruction registered instruction to decode
//   valid       1 = PC/instruction hold a real fetched instruction
//   stallCount  cycles with freeze=1 and flush=0 since reset (saturating)
//   flushCount  cycles with flush=1 since reset (saturating)
module ifid_pipe_reg #(
    parameter int unsigned          WORD_LEN  = 32,
    parameter logic [WORD_LEN-1:0]  NOP_INSTR = WORD_LEN'(0),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [WORD_LEN-1:0] pcIn,
    input  logic [WORD_LEN-1:0] instrIn,
    input  logic                freeze,
    input  logic                flush,
    output logic [WORD_LEN-1:0] PC,
    output logic [WORD_LEN-1:0] instruction,
    output logic                valid,
    output logic [CNT_W-1:0]    stallCount,
    output logic [CNT_W-1:0]    flushCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WORD_LEN-1:0] pc_q,    pc_d;
    logic [WORD_LEN-1:0] instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    // Next-state: flush > freeze > load; counters saturate instead of wrapping.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            pc_d    = WORD_LEN'(0);
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (freeze) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else begin
            pc_d    = pcIn;
            instr_d = instrIn;
            valid_d = 1'b1;
        end
    end

    // State registers; reset forces the bubble and clears the counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= WORD_LEN'(0);
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            stall_cnt_q <= CNT_W'(0);
            flush_cnt_q <= CNT_W'(0);
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC          = pc_q;
    assign instruction = instr_q;
    assign valid       = valid_q;
    assign stallCount  = stall_cnt_q;
    assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Directed testbench for ifid_pipe_reg.
// It uses a default instance and a CNT_W=4 instance for the saturation checks.
module tb_ifid_pipe_reg;

    logic        clk;
    logic        rstn;
    logic [31:0] pcIn;
    logic [31:0] instrIn;
    logic        freeze;
    logic        flush;

    logic [31:0] PC;
    logic [31:0] instruction;
    logic        valid;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    logic [31:0] s_PC;
    logic [31:0] s_instruction;
    logic        s_valid;
    logic [3:0]  s_stallCount;
    logic [3:0]  s_flushCount;

    int checks;
    int errors;

    ifid_pipe_reg dut (
        .clk(clk), .rstn(rstn), .pcIn(pcIn), .instrIn(instrIn),
        .freeze(freeze), .flush(flush), .PC(PC), .instruction(instruction),
        .valid(valid), .stallCount(stallCount), .flushCount(flushCount)
    );

    ifid_pipe_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rstn(rstn), .pcIn(pcIn), .instrIn(instrIn),
        .freeze(freeze), .flush(flush), .PC(s_PC), .instruction(s_instruction),
        .valid(s_valid), .stallCount(s_stallCount), .flushCount(s_flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; freeze = 1'b0; flush = 1'b0;
        pcIn = 32'h0; instrIn = 32'h0;
        tick(); tick();
        rstn = 1'b1;
        pcIn = 32'h40; instrIn = 32'hDEAD0040;
        tick();
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL pre_reset_pc: got %h exp %h", PC, 32'h40); end
        // Pull reset mid-cycle; outputs must clear without a clock edge.
        #2 rstn = 1'b0;
        #1;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", PC); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instruction); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
        checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d exp 0", stallCount); end
        checks++; if (flushCount !== 16'd0) begin errors++; $display("FAIL reset_flush: got %0d exp 0", flushCount); end
        tick();
        rstn = 1'b1;
        pcIn = 32'h0; instrIn = 32'hE0000001;
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL first_load_pc: got %h exp 0", PC); end
        checks++; if (instruction !== 32'hE0000001) begin errors++; $display("FAIL first_load_instr: got %h exp e0000001", instruction); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_load_valid: got %b exp 1", valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_pc;
        logic [31:0] exp_in;
        for (int i = 1; i <= 3; i++) begin
            exp_pc = 32'(4 * i);
            exp_in = 32'h10000000 + 32'(i * 32'h111);
            pcIn = exp_pc; instrIn = exp_in;
            tick();
            checks++; if (PC !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, PC, exp_pc); end
            checks++; if (instruction !== exp_in) begin errors++; $display("FAIL stream_instr[%0d]: got %h exp %h", i, instruction, exp_in); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, valid); end
            checks++; if (stallCount !== 16'd0 || flushCount !== 16'd0) begin errors++; $display("FAIL stream_counters[%0d]: got %0d/%0d exp 0/0", i, stallCount, flushCount); end
        end
    endtask

    task automatic test_freeze_hold();
        pcIn = 32'h8; instrIn = 32'hA5A50008;
        tick();
        freeze = 1'b1;
        pcIn = 32'hC; instrIn = 32'hC0DE000C;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (PC !== 32'h8) begin errors++; $display("FAIL freeze_pc[%0d]: got %h exp 8", i, PC); end
            checks++; if (instruction !== 32'hA5A50008) begin errors++; $display("FAIL freeze_instr[%0d]: got %h exp a5a50008", i, instruction); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL freeze_valid[%0d]: got %b exp 1", i, valid); end
            checks++; if (stallCount !== 16'(i)) begin errors++; $display("FAIL freeze_stall[%0d]: got %0d exp %0d", i, stallCount, i); end
        end
        freeze = 1'b0;
        tick();
        checks++; if (PC !== 32'hC) begin errors++; $display("FAIL unfreeze_pc: got %h exp c", PC); end
        checks++; if (instruction !== 32'hC0DE000C) begin errors++; $display("FAIL unfreeze_instr: got %h exp c0de000c", instruction); end
        checks++; if (stallCount !== 16'd3) begin errors++; $display("FAIL unfreeze_stall: got %0d exp 3", stallCount); end
        checks++; if (flushCount !== 16'd0) begin errors++; $display("FAIL unfreeze_flush: got %0d exp 0", flushCount); end
    endtask

    task automatic test_flush_priority();
        // Flush and freeze on the same edge: flush wins.
        flush = 1'b1; freeze = 1'b1;
        pcIn = 32'h10; instrIn = 32'hBAD00010;
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL flush_pc: got %h exp 0", PC); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL flush_instr: got %h exp 0", instruction); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", valid); end
        checks++; if (flushCount !== 16'd1) begin errors++; $display("FAIL flush_count: got %0d exp 1", flushCount); end
        checks++; if (stallCount !== 16'd3) begin errors++; $display("FAIL flush_stall_kept: got %0d exp 3", stallCount); end
        // A second consecutive flush.
        freeze = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %b exp 0", valid); end
        checks++; if (flushCount !== 16'd2) begin errors++; $display("FAIL flush2_count: got %0d exp 2", flushCount); end
        // A freeze while a bubble is held keeps the bubble.
        flush = 1'b0; freeze = 1'b1;
        tick();
        checks++; if (valid !== 1'b0 || PC !== 32'h0) begin errors++; $display("FAIL bubble_hold: got valid=%b pc=%h exp 0/0", valid, PC); end
        checks++; if (stallCount !== 16'd4) begin errors++; $display("FAIL bubble_stall: got %0d exp 4", stallCount); end
        freeze = 1'b0;
        pcIn = 32'h20; instrIn = 32'h00200020;
        tick();
        checks++; if (PC !== 32'h20) begin errors++; $display("FAIL post_flush_pc: got %h exp 20", PC); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid: got %b exp 1", valid); end
        checks++; if (flushCount !== 16'd2) begin errors++; $display("FAIL post_flush_count: got %0d exp 2", flushCount); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_sat;
        #2 rstn = 1'b0;
        tick();
        rstn = 1'b1;
        freeze = 1'b1; flush = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_sat = (i > 15) ? 4'd15 : 4'(i);
            checks++; if (s_stallCount !== exp_sat) begin errors++; $display("FAIL sat_stall[%0d]: got %0d exp %0d", i, s_stallCount, exp_sat); end
            checks++; if (stallCount !== 16'(i)) begin errors++; $display("FAIL wide_stall[%0d]: got %0d exp %0d", i, stallCount, i); end
        end
        freeze = 1'b0;
        pcIn = 32'h30; instrIn = 32'h30303030;
        tick();
        checks++; if (s_stallCount !== 4'd15) begin errors++; $display("FAIL sat_stall_after: got %0d exp 15", s_stallCount); end
        checks++; if (s_PC !== 32'h30 || s_valid !== 1'b1) begin errors++; $display("FAIL sat_load: got pc=%h valid=%b exp 30/1", s_PC, s_valid); end
    endtask

    task automatic test_async_reset();
        #2 rstn = 1'b0;
        tick();
        rstn = 1'b1;
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stallCount !== 16'd5) begin errors++; $display("FAIL pre_async_stall: got %0d exp 5", stallCount); end
        // Reset between edges, with freeze and flush unknown.
        #2 rstn = 1'b0;
        freeze = 1'bx; flush = 1'bx;
        #1;
        checks++; if (stallCount !== 16'd0 || flushCount !== 16'd0) begin errors++; $display("FAIL async_counters: got %0d/%0d exp 0/0", stallCount, flushCount); end
        checks++; if (PC !== 32'h0 || instruction !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL async_outputs: got pc=%h instr=%h valid=%b exp 0/0/0", PC, instruction, valid); end
        tick();
        checks++; if (valid !== 1'b0 || s_stallCount !== 4'd0) begin errors++; $display("FAIL async_held: got valid=%b sat_stall=%0d exp 0/0", valid, s_stallCount); end
        freeze = 1'b0; flush = 1'b0;
        pcIn = 32'h44; instrIn = 32'h12345678;
        rstn = 1'b1;
        tick();
        checks++; if (PC !== 32'h44) begin errors++; $display("FAIL release_pc: got %h exp 44", PC); end
        checks++; if (instruction !== 32'h12345678) begin errors++; $display("FAIL release_instr: got %h exp 12345678", instruction); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b exp 1", valid); end
        checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL release_stall: got %0d exp 0", stallCount); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_freeze_hold();
        test_flush_priority();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
- IF/ID pipeline register sitting directly downstream of the instruction-fetch stage.
- Captures the fetched PC and instruction word each cycle and presents them to the decode stage.
- Honours the same freeze (load-use stall) as the PC register, and squashes wrong-path fetches on a taken branch.
- Tracks a valid bit and saturating stall/flush event counters for performance debug.

Parameters:
- WORD_LEN, 32, width of PC and instruction words.
- NOP_INSTR, 32'd0, instruction word inserted on reset or flush (bubble).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- pcIn  input  WORD_LEN  PC from fetch stage (address of instrIn)
- instrIn  input  WORD_LEN  instruction word from fetch stage
- freeze  input  1  hold current contents (same signal that gates the fetch PC register)
- flush  input  1  squash; driven by brTaken
- PC  output  WORD_LEN  registered PC to decode
- instruction  output  WORD_LEN  registered instruction to decode
- valid  output  1  1 = PC/instruction hold a real fetched instruction
- stallCount  output  CNT_W  number of cycles with freeze=1 and flush=0 since reset
- flushCount  output  CNT_W  number of cycles with flush=1 since reset

Behaviour:
- Reset (rstn=0, asynchronous, effective immediately regardless of clk):
  - PC=0, instruction=NOP_INSTR, valid=0, stallCount=0, flushCount=0.
  - Outputs held at these values while rstn=0.
- Release: rstn is synchronously deasserted by the system. The first rising edge with rstn=1 is a normal capture edge.
- Priority at each rising edge: flush > freeze > load.
- flush=1 (any freeze value):
  - PC<=0, instruction<=NOP_INSTR, valid<=0.
  - flushCount increments; stallCount unchanged.
- freeze=1, flush=0:
  - PC, instruction, valid hold their values.
  - stallCount increments; flushCount unchanged.
- freeze=0, flush=0 (load):
  - PC<=pcIn, instruction<=instrIn, valid<=1.
  - Counters unchanged.
- Latency: one cycle from pcIn/instrIn to PC/instruction. No combinational path from any input to any output.
- Counters:
  - Unsigned, saturating at 2^CNT_W-1; they never wrap.
  - Cleared only by reset.
- Simultaneous flush+freeze: treated as flush. Bubble inserted, only flushCount increments. Rationale: branch outcome invalidates the held wrong-path instruction.
- Consecutive flushes: each cycle inserts a bubble and increments flushCount. valid stays 0 until the first load cycle.
- Freeze while valid=0: the bubble is held; valid stays 0.
- Reset mid-stall or mid-flush: reset overrides everything. The next edge after release behaves purely on that edge's inputs; no pending state survives reset.
- X-safety: with rstn=0, outputs are defined even if freeze/flush are X.

Test Plan:
- Reset/load:
  - Stimulus: assert rstn=0 mid-cycle with PC=0x40 → outputs immediately PC=0, instruction=0, valid=0, counters 0. Release rstn.
  - Stimulus: drive pcIn=0x0, instrIn=0xE0000001 → after one edge PC=0x0, instruction=0xE0000001, valid=1.
- Streaming:
  - Stimulus: pcIn=0x4,0x8,0xC with distinct instrIn on three consecutive edges, freeze=flush=0.
  - Response: outputs track with exactly one-cycle lag; valid=1 throughout; counters stay 0.
- Freeze hold:
  - Stimulus: with PC=0x8 captured, hold freeze=1 for 3 edges while pcIn changes to 0xC.
  - Response: PC=0x8 and instruction unchanged for all 3 cycles; stallCount=3.
  - Then freeze=0 → PC=0xC on the next edge.
- Flush priority:
  - Stimulus: assert flush=1 and freeze=1 on the same edge with valid=1.
  - Response: PC=0, instruction=NOP_INSTR, valid=0; flushCount+1; stallCount unchanged.
  - Next load edge with pcIn=0x20 → PC=0x20, valid=1.
- Saturation:
  - Stimulus: CNT_W=4, hold freeze=1 for 20 edges.
  - Response: stallCount reaches 15 and stays 15; no wrap to 0.
- Async reset mid-operation:
  - Stimulus: freeze=1, stallCount=5; pulse rstn low between edges.
  - Response: immediate clear of all outputs and counters. First edge after release with freeze=0 loads pcIn normally.
